inst_rom_loader: RTL and testbench
==================================

// Module: inst_rom_loader
// PURPOSE
//   Writer side of the instruction-memory word interface. Receives a program image as a byte
//   stream (valid/ready) and packs each 4 bytes, big-endian, into one 32-bit word.
//   Writes each word to the instruction RAM at word index 0..WORD_COUNT-1 (same word-index
//   addressing the fetch side reads with), then checks an XOR checksum byte.
//   Holds the CPU in reset while a load is in progress.
// PARAMETERS
//   ADDR_W      8      word-address width of wr_addr
//   WORD_COUNT  110    words per image; legal range 1..2**ADDR_W
//   TIMEOUT     65535  max idle cycles between bytes in RECV/CHECK before abort with error
// PORTS
//   clk         in   1       clock, rising edge
//   resetn      in   1       asynchronous active-low reset
//   start       in   1       pulse: begin a load (honoured in IDLE and DONE only)
//   byte_valid  in   1       byte_data is valid
//   byte_data   in   8       image byte; first byte of each word goes to bits [31:24]
//   byte_ready  out  1       loader accepts byte this cycle
//   wr_en       out  1       instruction RAM write strobe, one cycle per word
//   wr_addr     out  ADDR_W  word index being written
//   wr_data     out  32      assembled instruction word
//   busy        out  1       load in progress
//   cpu_hold    out  1       keep CPU in reset; equals busy
//   done        out  1       image loaded and checksum OK; sticky until next start
//   err         out  1       checksum mismatch or timeout; sticky until next start
// BEHAVIOUR
//   Reset (async, resetn=0): state=IDLE. All outputs 0, including wr_addr and wr_data.
//     Byte counter, word index, checksum and timeout counter cleared.
//   Transfer: a byte is accepted on a rising edge where byte_valid && byte_ready.
//     - byte_ready is a registered function of state: 1 only in RECV and CHECK.
//   FSM states: IDLE, RECV, WRITE, CHECK, DONE.
//   - IDLE: start -> RECV. Clears word index, byte count, checksum, done, err. Sets busy.
//   - RECV, on each accepted byte:
//       asm <= {asm[23:0], byte}; csum <= csum ^ byte; bcnt++ (2-bit, wraps).
//     The 4th accepted byte -> WRITE.
//   - WRITE, exactly one cycle: wr_en=1, wr_addr=word index, wr_data=asm, byte_ready=0.
//     Latency: 4th byte accepted at edge N -> wr_en high in the cycle after edge N.
//     Then: if word index==WORD_COUNT-1 -> CHECK; else word index++ and -> RECV.
//   - CHECK: accept one byte. If it equals csum (XOR of all image bytes):
//       done<=1, else err<=1. Either way -> DONE.
//   - DONE: busy=0 (so cpu_hold=0). done/err held.
//     start -> RECV with flags cleared, exactly as from IDLE.
//   wr_en is 0 in every state except WRITE. wr_addr and wr_data hold their last value otherwise.
//   Timeout counter:
//     - cleared on every accepted byte and on entry to RECV; counts in RECV/CHECK.
//     - On reaching TIMEOUT: err<=1 -> DONE. No further writes; words already written remain.
//   start while busy (RECV/WRITE/CHECK) is ignored.
//   byte_valid outside RECV/CHECK is ignored; no byte is consumed.
//   resetn low mid-load: immediate return to IDLE. Partial image is abandoned.
//     cpu_hold drops to 0; the integrating top must keep the CPU reset via resetn in that case.
//   Word index never exceeds WORD_COUNT-1. No wrap to 0 within one load.
// TESTING
//   1. WORD_COUNT=2; start; bytes AC 01 00 00 AC 02 00 04 07 ->
//      wr_en at addr0=32'hAC010000, then addr1=32'hAC020004. Then done=1, err=0, busy=0.
//   2. Same image, checksum byte 08 -> err=1, done=0. Both words still written exactly once.
//   3. byte_valid toggled 1-0-1 randomly, 50% duty ->
//      identical wr_en/addr/data sequence as test 1, one wr_en per 4 accepted bytes.
//   4. TIMEOUT=16; stop after 5 bytes ->
//      exactly one write (addr0). err=1 on the 17th idle cycle, cpu_hold=0.
//   5. resetn pulsed low after 6 bytes -> all outputs 0 asynchronously.
//      Fresh start then reloads correctly from addr0.
//   6. start pulsed during RECV -> ignored, load completes normally.
//      start in DONE -> flags clear, new load begins at addr0.

Source files
------------

// File: rtl/inst_rom_loader_if.sv
// Byte-stream handshake between an image source and the instruction ROM loader.
interface inst_rom_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/inst_rom_loader.sv
// Packs a big-endian byte stream into 32-bit instruction words, writes them to the
// instruction RAM, verifies a trailing XOR checksum and holds the CPU while loading.
module inst_rom_loader #(
  parameter int ADDR_W     = 8,
  parameter int WORD_COUNT = 110,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  inst_rom_loader_if.slave  byte_if,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int                TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORD_COUNT - 1);

  function automatic logic [7:0] csum_next(input logic [7:0] c, input logic [7:0] b);
    return c ^ b;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic [23:0]       asm_r;
  logic [7:0]        csum_r;
  logic [1:0]        bcnt_r;
  logic [ADDR_W-1:0] widx_r;
  logic [TW-1:0]     tcnt_r;
  logic              done_r;
  logic              err_r;
  logic              busy_r;
  logic              byte_ready_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic              byte_ready_s;
  logic              busy_s;
  logic              wr_en_s;

  logic acc_s;
  logic last_byte_s;
  logic last_word_s;
  logic tmo_s;
  logic begin_s;

  assign acc_s       = byte_if.byte_valid & byte_ready_r;
  assign last_byte_s = (bcnt_r == 2'd3);
  assign last_word_s = (widx_r == LAST_IDX);
  assign tmo_s       = !acc_s && (tcnt_r == T_LAST);
  assign begin_s     = start && ((state_r == IDLE) || (state_r == DONE));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? RECV : IDLE;
      RECV: begin
        if (acc_s && last_byte_s) begin
          state_nxt_s = WRITE;
        end else if (tmo_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RECV;
        end
      end
      WRITE:   state_nxt_s = last_word_s ? CHECK : RECV;
      CHECK:   state_nxt_s = (acc_s || tmo_s) ? DONE : CHECK;
      DONE:    state_nxt_s = start ? RECV : DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode, evaluated on the upcoming state so the registered outputs track it.
  always_comb begin
    byte_ready_s = 1'b0;
    busy_s       = 1'b0;
    wr_en_s      = 1'b0;
    if ((state_nxt_s == RECV) || (state_nxt_s == CHECK)) begin
      byte_ready_s = 1'b1;
    end else begin
      byte_ready_s = 1'b0;
    end
    if ((state_nxt_s == RECV) || (state_nxt_s == WRITE) || (state_nxt_s == CHECK)) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
    if ((state_r == RECV) && (state_nxt_s == WRITE)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Registered outputs; write address/data only change when a word is emitted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= 32'h0000_0000;
    end else begin
      byte_ready_r <= byte_ready_s;
      busy_r       <= busy_s;
      wr_en_r      <= wr_en_s;
      if (wr_en_s) begin
        wr_addr_r <= widx_r;
        wr_data_r <= {asm_r, byte_if.byte_data};
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

  // Datapath: byte assembly, checksum, word index, idle timer and status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      asm_r  <= 24'h00_0000;
      csum_r <= 8'h00;
      bcnt_r <= 2'd0;
      widx_r <= '0;
      tcnt_r <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (begin_s) begin
      asm_r  <= 24'h00_0000;
      csum_r <= 8'h00;
      bcnt_r <= 2'd0;
      widx_r <= '0;
      tcnt_r <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state_r)
        RECV: begin
          if (acc_s) begin
            asm_r  <= {asm_r[15:0], byte_if.byte_data};
            csum_r <= csum_next(csum_r, byte_if.byte_data);
            bcnt_r <= bcnt_r + 2'd1;
            tcnt_r <= '0;
          end else if (tmo_s) begin
            err_r <= 1'b1;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        WRITE: begin
          tcnt_r <= '0;
          if (!last_word_s) begin
            widx_r <= widx_r + ADDR_W'(1);
          end else begin
            widx_r <= widx_r;
          end
        end
        CHECK: begin
          if (acc_s) begin
            done_r <= (byte_if.byte_data == csum_r);
            err_r  <= (byte_if.byte_data != csum_r);
          end else if (tmo_s) begin
            err_r <= 1'b1;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        default: begin
          tcnt_r <= tcnt_r;
        end
      endcase
    end
  end

  assign byte_if.byte_ready = byte_ready_r;
  assign wr_en              = wr_en_r;
  assign wr_addr            = wr_addr_r;
  assign wr_data            = wr_data_r;
  assign busy               = busy_r;
  assign cpu_hold           = busy_r;
  assign done               = done_r;
  assign err                = err_r;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: table of whole-image loads plus timeout,
// mid-load reset and start-while-busy / restart-from-DONE sequences.
module tb_inst_rom_loader;
  logic       clk;
  logic       resetn;
  logic       start;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  logic       busy;
  logic       cpu_hold;
  logic       done;
  logic       err;

  inst_rom_loader_if lif ();

  inst_rom_loader #(.ADDR_W(8), .WORD_COUNT(2), .TIMEOUT(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .byte_if  (lif),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [39:0] wq[$];
  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [71:0] img;
    bit          rnd;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit rnd);
    bit r;
    int n;
    int zeros;
    n = 0;
    zeros = 0;
    while (1) begin
      lif.byte_valid = 1'b1;
      if (rnd && zeros < 3 && $urandom_range(0, 1) == 0) begin
        lif.byte_valid = 1'b0;
        zeros++;
      end else begin
        zeros = 0;
      end
      lif.byte_data = b;
      @(negedge clk);
      r = lif.byte_ready && lif.byte_valid;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 60) begin
        check("send_bound", 64'(n), 64'd0);
        break;
      end
    end
    lif.byte_valid = 1'b0;
  endtask

  // Sends bytes lo..hi of a 9-byte image; checks write latency after bytes 3 and 7.
  task automatic send_range(input logic [71:0] img, input bit rnd, input int lo, input int hi,
                            input string tag);
    for (int i = lo; i <= hi; i++) begin
      send(img[71-8*i -: 8], rnd);
      if (i == 3) check({tag, "_lat_w0"}, {63'd0, wr_en}, 64'd1);
      if (i == 7) check({tag, "_lat_w1"}, {63'd0, wr_en}, 64'd1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_words(input string tag, input logic [31:0] w0, input logic [31:0] w1);
    logic [39:0] e0;
    logic [39:0] e1;
    e0 = (wq.size() > 0) ? wq[0] : 40'hFF_FFFF_FFFF;
    e1 = (wq.size() > 1) ? wq[1] : 40'hFF_FFFF_FFFF;
    check({tag, "_nwr"}, 64'(wq.size()), 64'd2);
    check({tag, "_w0"}, 64'(e0), {24'd0, 8'h00, w0});
    check({tag, "_w1"}, 64'(e1), {24'd0, 8'h01, w1});
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_outs"}, {53'd0, lif.byte_ready, wr_en, busy, cpu_hold, done, err, 5'd0},
          64'd0);
    check({tag, "_addr_data"}, {24'd0, wr_addr, wr_data}, 64'd0);
  endtask

  initial begin
    logic ok;
    logic [71:0] img_a;
    logic [71:0] img_b;
    img_a = 72'hAC_01_00_00_AC_02_00_04_07;
    img_b = 72'h12_34_56_78_9A_BC_DE_F0_00;

    vecs[0] = '{img: img_a, rnd: 1'b0, w0: 32'hAC010000, w1: 32'hAC020004,
                exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{img: 72'hAC_01_00_00_AC_02_00_04_08, rnd: 1'b0, w0: 32'hAC010000,
                w1: 32'hAC020004, exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{img: img_a, rnd: 1'b1, w0: 32'hAC010000, w1: 32'hAC020004,
                exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{img: img_b, rnd: 1'b0, w0: 32'h12345678, w1: 32'h9ABCDEF0,
                exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{img: 72'hFF_FF_FF_FF_00_00_00_01_00, rnd: 1'b1, w0: 32'hFFFFFFFF,
                w1: 32'h00000001, exp_done: 1'b0, exp_err: 1'b1};

    resetn = 1'b0;
    start = 1'b0;
    lif.byte_valid = 1'b0;
    lif.byte_data = 8'h00;
    #3;
    check_outs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("v%0d", v);
      wq.delete();
      pulse_start();
      check({tag, "_busy"}, {62'd0, busy, cpu_hold}, 64'd3);
      send_range(vecs[v].img, vecs[v].rnd, 0, 8, tag);
      check_words(tag, vecs[v].w0, vecs[v].w1);
      check({tag, "_flags"}, {62'd0, done, err}, {62'd0, vecs[v].exp_done, vecs[v].exp_err});
      check({tag, "_idle"}, {61'd0, busy, cpu_hold, lif.byte_ready}, 64'd0);
    end

    // Idle timeout after five bytes: one word written, err on the 17th idle cycle.
    wq.delete();
    pulse_start();
    send_range(img_a, 1'b0, 0, 4, "tmo");
    ok = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (err !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check("tmo_pre", {63'd0, ok}, 64'd1);
    check("tmo_flags", {61'd0, err, done, cpu_hold}, 64'd4);
    repeat (5) @(posedge clk);
    #1;
    check("tmo_nwr", 64'(wq.size()), 64'd1);
    check("tmo_w0", 64'((wq.size() > 0) ? wq[0] : 40'hFF_FFFF_FFFF), 64'h00_AC010000);

    // Asynchronous reset mid-load, then a clean reload.
    wq.delete();
    pulse_start();
    send_range(img_a, 1'b0, 0, 5, "rst");
    #2;
    resetn = 1'b0;
    #1;
    check_outs_zero("rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    wq.delete();
    pulse_start();
    send_range(img_b, 1'b0, 0, 8, "reload");
    check_words("reload", 32'h12345678, 32'h9ABCDEF0);
    check("reload_flags", {62'd0, done, err}, 64'd2);

    // start while receiving is ignored.
    wq.delete();
    pulse_start();
    send_range(img_a, 1'b0, 0, 1, "sbusy");
    pulse_start();
    send_range(img_a, 1'b0, 2, 8, "sbusy");
    check_words("sbusy", 32'hAC010000, 32'hAC020004);
    check("sbusy_flags", {62'd0, done, err}, 64'd2);

    // byte_valid in DONE is not consumed.
    lif.byte_valid = 1'b1;
    lif.byte_data = 8'h5A;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (lif.byte_ready !== 1'b0) ok = 1'b0;
    end
    lif.byte_valid = 1'b0;
    @(posedge clk);
    #1;
    check("done_noready", {63'd0, ok}, 64'd1);
    check("done_nwr", 64'(wq.size()), 64'd2);

    // start from DONE clears the flags and restarts at word 0.
    wq.delete();
    pulse_start();
    check("restart_flags", {61'd0, done, err, busy}, 64'd1);
    send_range(img_b, 1'b1, 0, 8, "restart");
    check_words("restart", 32'h12345678, 32'h9ABCDEF0);
    check("restart_done", {62'd0, done, err}, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
